// File: rtl/alu_regfile.sv
// alu_regfile: 32x32 register file with a busy scoreboard that stalls reads of registers whose writes are still in flight
module alu_regfile #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_en,
   input  logic [AW-1:0] rs1_addr,
   input  logic [AW-1:0] rs2_addr,
   output logic [DW-1:0] rs1,
   output logic [DW-1:0] rs2,
   output logic          rs_valid,
   output logic          stall,
   input  logic          issue_en,
   input  logic [AW-1:0] issue_addr,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] rd
);
   localparam int N = 2**AW;
   logic [DW-1:0] mem [N];
   logic [N-1:0]  busy;
   logic [DW-1:0] v1, v2;
   logic          b1, b2, hit1, hit2;
   always_comb begin
      hit1  = we && wa == rs1_addr;
      hit2  = we && wa == rs2_addr;
      v1    = rs1_addr == '0 ? '0 : hit1 ? rd : mem[rs1_addr];
      v2    = rs2_addr == '0 ? '0 : hit2 ? rd : mem[rs2_addr];
      b1    = busy[rs1_addr] && !hit1;
      b2    = busy[rs2_addr] && !hit2;
      stall = rd_en && (b1 || b2);
   end
   // issue is applied after writeback so a same-cycle issue to the written address leaves it busy
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
         busy     <= '0;
         rs1      <= '0;
         rs2      <= '0;
         rs_valid <= 1'b0;
      end else begin
         rs_valid <= rd_en && !stall;
         if (rd_en && !stall) begin
            rs1 <= v1;
            rs2 <= v2;
         end
         if (we && wa != '0) begin
            mem[wa]  <= rd;
            busy[wa] <= 1'b0;
         end
         if (issue_en && !stall && issue_addr != '0) busy[issue_addr] <= 1'b1;
      end
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed vectors with a queue scoreboard checked by a negedge monitor
module tb_alu_regfile;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd_en = 1'b0, issue_en = 1'b0, we = 1'b0;
   logic [4:0]  rs1_addr = '0, rs2_addr = '0, issue_addr = '0, wa = '0;
   logic [31:0] rd = '0;
   logic [31:0] rs1, rs2;
   logic        rs_valid, stall;
   logic [63:0] q [$];
   int          checks = 0, errors = 0;

   alu_regfile dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1(rs1), .rs2(rs2), .rs_valid(rs_valid), .stall(stall), .issue_en(issue_en),
      .issue_addr(issue_addr), .we(we), .wa(wa), .rd(rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      we = 1'b0;
      rd_en = 1'b0;
      issue_en = 1'b0;
   endtask

   task automatic rdreq(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] e1, input logic [31:0] e2);
      rd_en = 1'b1;
      rs1_addr = a1;
      rs2_addr = a2;
      q.push_back({e1, e2});
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1;
      wa = a;
      rd = d;
   endtask

   task automatic iss(input logic [4:0] a);
      issue_en = 1'b1;
      issue_addr = a;
   endtask

   always @(negedge clk)
      if (reset && rs_valid) begin
         if (q.size() == 0) chk("unexpected_rs_valid", 64'd1, 64'd0);
         else chk("operands", {rs1, rs2}, q.pop_front());
      end

   initial begin
      #2 reset = 1'b0;
      #10;
      chk("reset_rs1", rs1, 0);
      chk("reset_rs2", rs2, 0);
      chk("reset_valid", rs_valid, 0);
      chk("reset_stall", stall, 0);
      reset = 1'b1;
      tick;
      rdreq(10, 20, 0, 0);
      tick;
      wr(3, 71);
      tick;
      rdreq(3, 0, 71, 0);
      tick;
      wr(5, 82);
      rdreq(5, 3, 82, 71);
      tick;
      wr(0, 16);
      tick;
      rdreq(0, 5, 0, 82);
      tick;
      iss(7);
      tick;
      rd_en = 1'b1; rs1_addr = 0; rs2_addr = 7;
      #1 chk("stall_busy", stall, 1);
      tick;
      chk("stall_no_valid", rs_valid, 0);
      wr(7, 24);
      rdreq(0, 7, 0, 24);
      #1 chk("stall_drop_on_wb", stall, 0);
      tick;
      rdreq(7, 3, 24, 71);
      iss(7);
      #1 chk("no_self_stall", stall, 0);
      tick;
      rd_en = 1'b1; rs1_addr = 7; rs2_addr = 0;
      #1 chk("stall_after_issue", stall, 1);
      tick;
      wr(7, 33);
      iss(7);
      tick;
      rd_en = 1'b1; rs1_addr = 7; rs2_addr = 0;
      #1 chk("issue_wins_over_wb", stall, 1);
      tick;
      wr(7, 44);
      rdreq(7, 5, 44, 82);
      tick;
      iss(9);
      tick;
      iss(11);
      tick;
      rd_en = 1'b1; rs1_addr = 9; rs2_addr = 0;
      iss(12);
      #1 chk("multi_outstanding", stall, 1);
      tick;
      rd_en = 1'b1; rs1_addr = 0; rs2_addr = 11;
      #1 chk("second_outstanding", stall, 1);
      tick;
      rdreq(12, 3, 0, 71);
      #1 chk("issue_ignored_on_stall", stall, 0);
      tick;
      tick;
      #2 reset = 1'b0;
      wr(4, 99);
      #1;
      chk("mid_reset_rs1", rs1, 0);
      chk("mid_reset_rs2", rs2, 0);
      chk("mid_reset_valid", rs_valid, 0);
      rd_en = 1'b1; rs1_addr = 9; rs2_addr = 11;
      #1 chk("mid_reset_busy_clear", stall, 0);
      tick;
      reset = 1'b1;
      rdreq(9, 4, 0, 0);
      #1 chk("post_reset_no_stall", stall, 0);
      tick;
      tick;
      tick;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Operand source and writeback sink for the `alu` datapath.
- Holds 32 x 32-bit architectural registers.
- Supplies registered rs1/rs2 operands to the ALU and accepts rd writeback from it.
- Keeps a per-register busy scoreboard so a read of a register with a write still in flight stalls until the writeback lands.

Parameters:
- DW, 32, data width of registers and operand/result buses.
- AW, 5, register address width; register count is 2**AW.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
- rd_en  in  1  operand read request.
- rs1_addr  in  AW  source register 1 address.
- rs2_addr  in  AW  source register 2 address.
- rs1  out  DW  registered operand 1 to ALU.
- rs2  out  DW  registered operand 2 to ALU.
- rs_valid  out  1  rs1/rs2 were updated by the last clock edge.
- stall  out  1  combinational; read request blocked by a busy source.
- issue_en  in  1  mark the destination of a newly issued ALU op as pending.
- issue_addr  in  AW  destination register of the issued op.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- rd  in  DW  writeback data (ALU result).

Behaviour:
- Reset (reset=0, async):
  - all registers cleared to 0; rs1=0, rs2=0, rs_valid=0.
  - all busy bits cleared, so stall=0.
  - Reset asserted mid-operation discards all in-flight busy state.
  - Writes and issues are ignored while reset=0.
- Register 0:
  - always reads 0.
  - writes to wa=0 are dropped.
  - issue to address 0 never sets busy.
- Effective read value val(a):
  - a==0 -> 0.
  - else if we && wa==a -> rd (same-cycle write bypass).
  - else mem[a].
- Effective busy bbusy(a): busy[a] && !(we && wa==a). A writeback landing this cycle unblocks the read.
- Stall: stall = rd_en && (bbusy(rs1_addr) || bbusy(rs2_addr)). Purely combinational.
- Read, posedge:
  - if rd_en && !stall: rs1<=val(rs1_addr), rs2<=val(rs2_addr), rs_valid<=1.
  - else rs_valid<=0 and rs1/rs2 hold their previous values.
  - Read latency is 1 cycle.
- Write, posedge: if we && wa!=0, mem[wa]<=rd and busy[wa]<=0.
- Issue, posedge:
  - if issue_en && !stall && issue_addr!=0, busy[issue_addr]<=1.
  - issue_en is ignored while stall=1; the requester must hold it.
- Simultaneous events:
  - issue and write to the same address in one cycle: busy ends at 1 (the new op is in flight) and mem still takes rd.
  - read and issue in the same cycle with issue_addr equal to a source: the read uses pre-issue busy, so it does not self-stall.
  - read and write to the same address in the same cycle: the read returns rd via the bypass.
- Multiple outstanding issues to different addresses are allowed.
- Re-issue to an already-busy address keeps busy=1 until the next writeback to it.

Test Plan:
- Reset:
  - Stimulus: pulse reset=0 asynchronously between clock edges.
  - Response: rs1=rs2=0, rs_valid=0, stall=0 immediately; a subsequent read of any address returns 0.
- Write then read:
  - Stimulus: we=1, wa=3, rd=71; next cycle rd_en=1, rs1_addr=3, rs2_addr=0.
  - Response: one edge later rs1=71, rs2=0, rs_valid=1.
- Bypass:
  - Stimulus: we=1, wa=5, rd=82 and rd_en=1, rs1_addr=5 in the same cycle.
  - Response: rs1=82 after that edge.
- Register 0:
  - Stimulus: write wa=0, rd=16.
  - Response: a read of 0 returns 0.
- Scoreboard stall:
  - Stimulus: issue_en, issue_addr=7; next cycle rd_en=1, rs2_addr=7.
  - Response: stall=1 and rs_valid=0.
  - Stimulus: then we=1, wa=7, rd=24.
  - Response: stall drops in that cycle; rs2=24 after the edge.
- Reset mid-flight:
  - Stimulus: issue to 9, then reset=0 before writeback.
  - Response: after reset releases, a read of 9 has no stall and returns 0.
